// File: rtl/apb4_reg_bank.sv
// APB4 slave register bank: RW/RO word registers, wait states,
// privilege-checked writes and per-register write strobes.
module apb4_reg_bank #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS = 16,
  parameter int WAIT_CYCLES = 0,
  parameter logic [NUM_REGS-1:0] RO_MASK = '0,
  parameter bit PRIV_WRITE = 1'b1
) (
  input  logic                         pclk,
  input  logic                         preset_n,
  input  logic [ADDR_WIDTH-1:0]        paddr,
  input  logic                         psel,
  input  logic                         penable,
  input  logic                         pwrite,
  input  logic [DATA_WIDTH-1:0]        pwdata,
  input  logic [DATA_WIDTH/8-1:0]      pstrb,
  input  logic [2:0]                   pprot,
  output logic                         pready,
  output logic [DATA_WIDTH-1:0]        prdata,
  output logic                         pslverr,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] status_d,
  output logic [NUM_REGS-1:0]          wr_pulse
);

  localparam int NB  = DATA_WIDTH / 8;
  localparam int OFF = $clog2(NB);
  localparam int IW  = ADDR_WIDTH - OFF;
  localparam int XW  = $clog2(NUM_REGS);
  localparam int CW  = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  typedef enum logic {IDLE, ACCESS} state_e;

  state_e                state_q;
  logic [CW-1:0]         cnt_q;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [NUM_REGS-1:0]   pulse_q;

  logic [IW-1:0] idx;
  logic [XW-1:0] widx;
  logic          hit;
  logic          ro;
  logic          err;
  logic          commit;
  logic          unused;

  assign unused = ^pprot[2:1];

  assign idx  = paddr[ADDR_WIDTH-1:OFF];
  assign widx = idx[XW-1:0];
  assign hit  = ({1'b0, idx} < (IW + 1)'(NUM_REGS));
  assign ro   = RO_MASK[widx];
  assign err  = !hit
              | (pwrite & ro)
              | (pwrite & PRIV_WRITE & !pprot[0]);

  assign pready = (state_q == ACCESS) && (cnt_q == '0)
                && psel && penable;
  assign pslverr = pready & err;
  assign commit  = pready & pwrite & !err;

  always_comb begin
    prdata = '0;
    if (pready && !pwrite && !err) begin
      prdata = ro ? status_d[widx*DATA_WIDTH +: DATA_WIDTH]
                  : regs_q[widx];
    end
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (psel && !penable) begin
            state_q <= ACCESS;
            cnt_q   <= CW'(WAIT_CYCLES);
          end
        end
        ACCESS: begin
          // psel low aborts; completion ends the transfer
          if (!psel || pready) begin
            state_q <= IDLE;
          end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      pulse_q <= '0;
    end else begin
      pulse_q <= '0;
      if (commit) begin
        pulse_q[widx] <= 1'b1;
        for (int b = 0; b < NB; b++) begin
          if (pstrb[b]) begin
            regs_q[widx][b*8 +: 8] <= pwdata[b*8 +: 8];
          end
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
    assign reg_q[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
  end

  assign wr_pulse = pulse_q;

endmodule

// File: tb/tb_apb4_reg_bank.sv
// Bench for apb4_reg_bank: zero-wait and 3-wait instances driven
// with directed and random APB traffic against a word-array model.
module tb_apb4_reg_bank;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NR = 16;
  localparam int FW = NR * DW;
  localparam logic [NR-1:0] RO = 16'hC000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [AW-1:0] paddr;
  logic          penable;
  logic          pwrite;
  logic [DW-1:0] pwdata;
  logic [3:0]    pstrb;
  logic [2:0]    pprot;

  logic          psel [2];
  logic          rdy  [2];
  logic [DW-1:0] rd   [2];
  logic          err  [2];
  logic [FW-1:0] rq   [2];
  logic [FW-1:0] st   [2];
  logic [NR-1:0] wp   [2];

  logic [NR-1:0] rom = RO;
  logic [DW-1:0] m [2][NR];
  logic [NR-1:0] pulse_nx [2];
  int            pulse_at [2];
  int            cyc;
  bit            mon_en;
  int            total;
  int            bad;

  apb4_reg_bank #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR),
    .WAIT_CYCLES(0), .RO_MASK(RO), .PRIV_WRITE(1'b1)
  ) u0 (
    .pclk(clk), .preset_n(rst_n), .paddr(paddr),
    .psel(psel[0]), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
    .pready(rdy[0]), .prdata(rd[0]), .pslverr(err[0]),
    .reg_q(rq[0]), .status_d(st[0]), .wr_pulse(wp[0])
  );

  apb4_reg_bank #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR),
    .WAIT_CYCLES(3), .RO_MASK(RO), .PRIV_WRITE(1'b1)
  ) u3 (
    .pclk(clk), .preset_n(rst_n), .paddr(paddr),
    .psel(psel[1]), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
    .pready(rdy[1]), .prdata(rd[1]), .pslverr(err[1]),
    .reg_q(rq[1]), .status_d(st[1]), .wr_pulse(wp[1])
  );

  task automatic chk(input string tag,
                     input logic [FW-1:0] got,
                     input logic [FW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mon_en) begin
      for (int d = 0; d < 2; d++) begin
        logic [NR-1:0] e;
        e = (cyc == pulse_at[d]) ? pulse_nx[d] : '0;
        chk($sformatf("wr_pulse%0d", d), wp[d], e);
      end
    end
  end

  task automatic clr_model();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < NR; i++) m[d][i] = '0;
      pulse_nx[d] = '0;
      pulse_at[d] = -1;
    end
  endtask

  task automatic chk_regs(input int d);
    logic [FW-1:0] f;
    for (int i = 0; i < NR; i++) f[i*DW +: DW] = m[d][i];
    chk($sformatf("reg_q%0d", d), rq[d], f);
  endtask

  task automatic idle();
    @(negedge clk);
    psel[0] = 1'b0;
    psel[1] = 1'b0;
    penable = 1'b0;
  endtask

  task automatic xfer(input int d, input bit wr,
                      input logic [AW-1:0] a,
                      input logic [DW-1:0] wd,
                      input logic [3:0] sb,
                      input logic [2:0] pp,
                      input bit gap);
    int idx;
    int waits;
    bit e;
    logic [DW-1:0] ev;
    idx = int'(a >> 2);
    e = (idx >= NR) || (wr && (rom[idx] || !pp[0]));
    ev = '0;
    if (!wr && !e) ev = rom[idx] ? st[d][idx*DW +: DW] : m[d][idx];
    @(negedge clk);
    paddr = a; pwrite = wr; pwdata = wd; pstrb = sb; pprot = pp;
    penable = 1'b0;
    psel[0] = 1'b0;
    psel[1] = 1'b0;
    psel[d] = 1'b1;
    @(negedge clk);
    penable = 1'b1;
    #1;
    waits = 0;
    while (!rdy[d] && waits < 20) begin
      chk("wait_prdata", rd[d], '0);
      chk("wait_slverr", err[d], '0);
      @(negedge clk);
      #1;
      waits++;
    end
    chk($sformatf("waits%0d", d), waits, (d == 1) ? 3 : 0);
    chk($sformatf("pslverr a=%0h", a), err[d], e);
    if (!wr) chk($sformatf("prdata a=%0h", a), rd[d], ev);
    if (wr && !e) begin
      for (int b = 0; b < 4; b++) begin
        if (sb[b]) m[d][idx][b*8 +: 8] = wd[b*8 +: 8];
      end
      pulse_nx[d] = '0;
      pulse_nx[d][idx] = 1'b1;
      pulse_at[d] = cyc + 1;
    end
    if (gap) idle();
  endtask

  initial begin
    total = 0;
    bad = 0;
    mon_en = 1'b0;
    cyc = 0;
    rst_n = 1'b0;
    paddr = '0; penable = 1'b0; pwrite = 1'b0;
    pwdata = '0; pstrb = '0; pprot = '0;
    psel[0] = 1'b0;
    psel[1] = 1'b0;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < NR; i++) st[d][i*DW +: DW] = $urandom();
    end
    clr_model();
    @(negedge clk);
    @(negedge clk);
    chk("rst_pready", rdy[0], '0);
    chk("rst_prdata", rd[0], '0);
    chk("rst_slverr", err[0], '0);
    chk("rst_pulse", wp[0], '0);
    chk_regs(0);
    chk_regs(1);
    rst_n = 1'b1;
    mon_en = 1'b1;

    xfer(0, 1'b1, 32'h4, 32'hDEADBEEF, 4'hF, 3'b001, 1'b1);
    chk("reg1_full", rq[0][63:32], 32'hDEADBEEF);
    xfer(0, 1'b1, 32'h4, 32'h11223344, 4'h5, 3'b001, 1'b1);
    chk("reg1_part", rq[0][63:32], 32'hDE22BE44);
    xfer(0, 1'b0, 32'h4, 32'h0, 4'h0, 3'b000, 1'b1);

    xfer(0, 1'b0, 32'h40, 32'h0, 4'hF, 3'b001, 1'b1);
    xfer(0, 1'b1, 32'h38, 32'hA5A5A5A5, 4'hF, 3'b001, 1'b1);
    xfer(0, 1'b1, 32'h8, 32'h12345678, 4'hF, 3'b000, 1'b1);
    xfer(0, 1'b0, 32'h38, 32'h0, 4'hF, 3'b001, 1'b1);
    chk_regs(0);

    xfer(0, 1'b1, 32'h8, 32'hCAFE0002, 4'hF, 3'b001, 1'b0);
    xfer(0, 1'b1, 32'hC, 32'hCAFE0003, 4'hF, 3'b001, 1'b1);
    xfer(0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 3'b011, 1'b1);
    chk_regs(0);

    xfer(1, 1'b1, 32'h0, 32'h0BADF00D, 4'hF, 3'b001, 1'b1);
    xfer(1, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000, 1'b1);

    @(negedge clk);
    paddr = 32'h8; pwrite = 1'b1; pwdata = 32'h55AA55AA;
    pstrb = 4'hF; pprot = 3'b001; penable = 1'b0;
    psel[1] = 1'b1;
    @(negedge clk);
    penable = 1'b1;
    #1;
    chk("abort_rdy", rdy[1], '0);
    idle();
    idle();
    chk_regs(1);

    for (int n = 0; n < 60; n++) begin
      logic [AW-1:0] a;
      a = AW'($urandom_range(0, 19) << 2) | AW'($urandom_range(0, 3));
      xfer(n % 2, 1'($urandom()), a, $urandom(), 4'($urandom()),
           3'($urandom()), 1'($urandom()));
      if (n % 10 == 9) begin
        idle();
        chk_regs(0);
        chk_regs(1);
      end
    end
    idle();

    @(negedge clk);
    paddr = 32'h14; pwrite = 1'b1; pwdata = 32'h77777777;
    pstrb = 4'hF; pprot = 3'b001; penable = 1'b0;
    psel[0] = 1'b1;
    @(negedge clk);
    penable = 1'b1;
    #1;
    chk("pre_rst_rdy", rdy[0], 1'b1);
    rst_n = 1'b0;
    clr_model();
    #1;
    chk("mid_rst_rdy", rdy[0], '0);
    chk("mid_rst_prdata", rd[0], '0);
    chk("mid_rst_slverr", err[0], '0);
    chk("mid_rst_pulse", wp[0], '0);
    chk_regs(0);
    chk_regs(1);
    psel[0] = 1'b0;
    penable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    xfer(0, 1'b1, 32'h14, 32'h01020304, 4'hF, 3'b001, 1'b1);
    chk_regs(0);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
